// File: rtl/calc1_port_sched_if.sv
// Signal bundle for calc1_port_sched: client command channel,
// the four calc1 port lanes, and the result channel.
interface calc1_port_sched_if;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_cmd;
    logic [31:0]  in_op1;
    logic [31:0]  in_op2;
    logic [3:0]   in_tag;
    logic [15:0]  req_cmd_out;
    logic [127:0] req_data_out;
    logic [7:0]   out_resp;
    logic [127:0] out_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_resp;
    logic [31:0]  rsp_data;
    logic [3:0]   rsp_tag;
    logic [1:0]   rsp_port;
    logic [3:0]   busy;
    logic         proto_err;

    modport slave (
        input  in_valid, in_cmd, in_op1, in_op2, in_tag,
        input  out_resp, out_data, rsp_ready,
        output in_ready, req_cmd_out, req_data_out,
        output rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_port,
        output busy, proto_err
    );

    modport master (
        output in_valid, in_cmd, in_op1, in_op2, in_tag,
        output out_resp, out_data, rsp_ready,
        input  in_ready, req_cmd_out, req_data_out,
        input  rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_port,
        input  busy, proto_err
    );
endinterface

// File: rtl/calc1_port_sched.sv
// Spreads client commands over four calc1 ports round-robin and
// returns each port's result (or a timeout) round-robin.
module calc1_port_sched #(
    parameter int TIMEOUT = 64
) (
    input  logic c_clk,
    input  logic reset,
    calc1_port_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND1, SEND2} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_busy;
    logic [3:0]   r_pend;
    logic [1:0]   r_dptr;
    logic [1:0]   r_pptr;
    logic [1:0]   r_port;
    logic [31:0]  r_op2;
    logic [15:0]  r_req_cmd;
    logic [127:0] r_req_data;
    logic [3:0]   r_ptag [4];
    logic [1:0]   r_code [4];
    logic [31:0]  r_data [4];
    logic [7:0]   r_timer [4];
    logic         r_lock;
    logic [1:0]   r_lport;
    logic         r_perr;

    logic         w_ready;
    logic         w_accept;
    logic         w_rvalid;
    logic         w_pop;
    logic [1:0]   w_dsel;
    logic [1:0]   w_psel;
    logic [1:0]   w_rport;
    logic [3:0]   w_cap;
    logic [3:0]   w_tinc;
    logic [3:0]   w_tout;
    logic         w_perr;

    assign w_ready  = reset & (r_state == IDLE) & ~(&r_busy);
    assign w_accept = bus.in_valid & w_ready;
    assign w_rvalid = |r_pend;
    assign w_rport  = r_lock ? r_lport : w_psel;
    assign w_pop    = w_rvalid & bus.rsp_ready;

    assign bus.in_ready     = w_ready;
    assign bus.req_cmd_out  = r_req_cmd;
    assign bus.req_data_out = r_req_data;
    assign bus.busy         = r_busy;
    assign bus.proto_err    = r_perr;
    assign bus.rsp_valid    = w_rvalid;
    assign bus.rsp_resp     = w_rvalid ? r_code[w_rport] : 2'd0;
    assign bus.rsp_data     = w_rvalid ? r_data[w_rport] : 32'd0;
    assign bus.rsp_tag      = w_rvalid ? r_ptag[w_rport] : 4'd0;
    assign bus.rsp_port     = w_rvalid ? w_rport : 2'd0;

    // First free port at or after the dispatch pointer.
    always_comb begin
        w_dsel = r_dptr;
        for (int k = 3; k >= 0; k--) begin
            if (!r_busy[r_dptr + 2'(k)]) w_dsel = r_dptr + 2'(k);
        end
    end

    // First pending result slot at or after the pop pointer.
    always_comb begin
        w_psel = r_pptr;
        for (int k = 3; k >= 0; k--) begin
            if (r_pend[r_pptr + 2'(k)]) w_psel = r_pptr + 2'(k);
        end
    end

    // Classify each port's response lane: capture, stray, timer tick, timeout.
    always_comb begin
        w_cap  = '0;
        w_tinc = '0;
        w_tout = '0;
        w_perr = 1'b0;
        for (int p = 0; p < 4; p++) begin
            w_cap[p]  = (|bus.out_resp[2*p +: 2]) & r_busy[p] & ~r_pend[p];
            w_perr    = w_perr | ((|bus.out_resp[2*p +: 2]) & ~w_cap[p]);
            w_tinc[p] = r_busy[p] & ~r_pend[p]
                      & ~((r_state == SEND1) & (r_port == 2'(p)));
            w_tout[p] = w_tinc[p] & ~(|bus.out_resp[2*p +: 2])
                      & (r_timer[p] == TMO_LAST);
        end
    end

    // Dispatch FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SEND1;
            SEND1:   w_state_nxt = SEND2;
            SEND2:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Dispatch FSM state register.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Port claim/release and the registered calc1 request lanes.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_busy     <= '0;
            r_dptr     <= '0;
            r_port     <= '0;
            r_op2      <= '0;
            r_req_cmd  <= '0;
            r_req_data <= '0;
            for (int p = 0; p < 4; p++) r_ptag[p] <= '0;
        end else begin
            r_req_cmd  <= '0;
            r_req_data <= '0;
            if (w_pop) r_busy[w_rport] <= 1'b0;
            if (w_accept) begin
                r_busy[w_dsel]  <= 1'b1;
                r_port          <= w_dsel;
                r_op2           <= bus.in_op2;
                r_ptag[w_dsel]  <= bus.in_tag;
                r_dptr          <= w_dsel + 2'd1;
                r_req_cmd[{w_dsel, 2'b00} +: 4]   <= bus.in_cmd;
                r_req_data[{w_dsel, 5'b0} +: 32]  <= bus.in_op1;
            end else if (r_state == SEND1) begin
                r_req_data[{r_port, 5'b0} +: 32]  <= r_op2;
            end
        end
    end

    // Result slots, response timers, pop arbitration and stray-response flag.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_pend  <= '0;
            r_pptr  <= '0;
            r_lock  <= 1'b0;
            r_lport <= '0;
            r_perr  <= 1'b0;
            for (int p = 0; p < 4; p++) begin
                r_code[p]  <= '0;
                r_data[p]  <= '0;
                r_timer[p] <= '0;
            end
        end else begin
            r_perr  <= w_perr;
            r_lock  <= w_rvalid & ~bus.rsp_ready;
            r_lport <= w_rport;
            for (int p = 0; p < 4; p++) begin
                if (w_cap[p]) begin
                    r_pend[p] <= 1'b1;
                    r_code[p] <= (bus.out_resp[2*p +: 2] == 2'd1) ? 2'd1 : 2'd2;
                    r_data[p] <= bus.out_data[32*p +: 32];
                end else if (w_tout[p]) begin
                    r_pend[p] <= 1'b1;
                    r_code[p] <= 2'd3;
                    r_data[p] <= '0;
                end
                if ((r_state == SEND1) && (r_port == 2'(p))) r_timer[p] <= '0;
                else if (w_tinc[p]) r_timer[p] <= r_timer[p] + 8'd1;
            end
            if (w_pop) begin
                r_pend[w_rport] <= 1'b0;
                r_pptr          <= w_rport + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_calc1_port_sched.sv
// Bench for calc1_port_sched: directed scenarios and random traffic,
// all outputs compared every cycle against a port-level reference model.
module tb_calc1_port_sched;
    localparam int TO = 8;

    logic c_clk = 1'b0;
    logic reset = 1'b0;

    calc1_port_sched_if bus ();

    calc1_port_sched #(.TIMEOUT(TO)) u_dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 c_clk = ~c_clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [3:0] cmds [4] = '{4'd1, 4'd2, 4'd5, 4'd6};

    // reference model: per-port occupancy, results, and deadlines
    int          m_ph;
    int          m_port;
    int          m_dptr;
    int          m_pptr;
    int          m_lock;
    logic [3:0]  m_cmd;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    bit          m_busy [4];
    bit          m_pend [4];
    logic [1:0]  m_code [4];
    logic [31:0] m_data [4];
    logic [3:0]  m_tag  [4];
    longint      m_sent [4];
    bit          m_perr;
    longint      cyc = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_ph = 0; m_port = 0; m_dptr = 0; m_pptr = 0; m_lock = -1;
        m_cmd = '0; m_op1 = '0; m_op2 = '0; m_perr = 0;
        for (int p = 0; p < 4; p++) begin
            m_busy[p] = 0; m_pend[p] = 0; m_code[p] = '0;
            m_data[p] = '0; m_tag[p] = '0; m_sent[p] = -1;
        end
    endtask

    function automatic bit any_pend();
        return m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
    endfunction

    function automatic bit all_busy();
        return m_busy[0] & m_busy[1] & m_busy[2] & m_busy[3];
    endfunction

    function automatic int m_sel();
        if (m_lock >= 0) return m_lock;
        for (int k = 0; k < 4; k++)
            if (m_pend[(m_pptr + k) % 4]) return (m_pptr + k) % 4;
        return 0;
    endfunction

    task automatic check_outputs();
        int s;
        bit rv;
        logic [15:0]  ec;
        logic [127:0] ed;
        logic [3:0]   eb;
        s  = m_sel();
        rv = any_pend();
        ec = '0; ed = '0; eb = '0;
        for (int p = 0; p < 4; p++) eb[p] = m_busy[p];
        if (m_ph == 1) begin
            ec[4*m_port +: 4]  = m_cmd;
            ed[32*m_port +: 32] = m_op1;
        end else if (m_ph == 2) begin
            ed[32*m_port +: 32] = m_op2;
        end
        check("in_ready", bus.in_ready, reset && m_ph == 0 && !all_busy());
        check("rsp_valid", bus.rsp_valid, rv);
        check("busy", bus.busy, eb);
        check("req_cmd", bus.req_cmd_out, ec);
        check("req_data", bus.req_data_out, ed);
        check("proto_err", bus.proto_err, m_perr);
        if (rv) begin
            check("rsp_port", bus.rsp_port, s[1:0]);
            check("rsp_resp", bus.rsp_resp, m_code[s]);
            check("rsp_data", bus.rsp_data, m_data[s]);
            check("rsp_tag", bus.rsp_tag, m_tag[s]);
        end else begin
            check("rsp_idle", {bus.rsp_resp, bus.rsp_data, bus.rsp_tag,
                               bus.rsp_port}, '0);
        end
    endtask

    task automatic model_edge();
        bit rv, pop, acc, nperr;
        bit nb [4];
        bit np [4];
        int s, d;
        logic [1:0] r;
        s     = m_sel();
        rv    = any_pend();
        pop   = rv && bus.rsp_ready;
        acc   = bus.in_valid && m_ph == 0 && !all_busy();
        nperr = 0;
        nb    = m_busy;
        np    = m_pend;
        for (int p = 0; p < 4; p++) begin
            r = bus.out_resp[2*p +: 2];
            if (r != 2'd0) begin
                if (m_busy[p] && !m_pend[p]) begin
                    np[p] = 1;
                    m_code[p] = (r == 2'd1) ? 2'd1 : 2'd2;
                    m_data[p] = bus.out_data[32*p +: 32];
                end else begin
                    nperr = 1;
                end
            end else if (m_busy[p] && !m_pend[p] && m_sent[p] >= 0 &&
                         cyc + 1 == m_sent[p] + TO) begin
                np[p] = 1;
                m_code[p] = 2'd3;
                m_data[p] = '0;
            end
        end
        if (pop) begin
            np[s]  = 0;
            nb[s]  = 0;
            m_pptr = (s + 1) % 4;
        end
        m_lock = (rv && !bus.rsp_ready) ? s : -1;
        case (m_ph)
            0: if (acc) begin
                d = -1;
                for (int k = 0; k < 4; k++)
                    if (d < 0 && !m_busy[(m_dptr + k) % 4]) d = (m_dptr + k) % 4;
                nb[d] = 1;
                m_port = d;
                m_cmd = bus.in_cmd;
                m_op1 = bus.in_op1;
                m_op2 = bus.in_op2;
                m_tag[d] = bus.in_tag;
                m_sent[d] = -1;
                m_dptr = (d + 1) % 4;
                m_ph = 1;
            end
            1: begin
                m_ph = 2;
                m_sent[m_port] = cyc + 1;
            end
            default: m_ph = 0;
        endcase
        m_busy = nb;
        m_pend = np;
        m_perr = nperr;
    endtask

    task automatic tick();
        #1;
        if (!reset) m_reset();
        check_outputs();
        if (reset) model_edge();
        @(posedge c_clk);
        #1;
        cyc++;
    endtask

    task automatic idle_in();
        bus.in_valid = 0; bus.in_cmd = '0; bus.in_op1 = '0; bus.in_op2 = '0;
        bus.in_tag = '0; bus.out_resp = '0; bus.out_data = '0;
        bus.rsp_ready = 0;
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] t);
        bus.in_valid = 1; bus.in_cmd = c; bus.in_op1 = a;
        bus.in_op2 = b; bus.in_tag = t;
        tick();
        bus.in_valid = 0;
        tick();
        tick();
    endtask

    task automatic drain();
        bus.rsp_ready = 1;
        repeat (12) tick();
        bus.rsp_ready = 0;
    endtask

    initial begin
        idle_in();
        m_reset();
        repeat (3) @(posedge c_clk);
        #1;
        check_outputs();
        reset = 1'b1;

        // four commands fill ports 1..4 in order
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1; bus.in_cmd = cmds[k];
            bus.in_op1 = 32'hA000_0000 + 32'(k);
            bus.in_op2 = 32'hB000_0000 + 32'(k);
            bus.in_tag = 4'(k + 8);
            tick();
            bus.in_valid = 0;
            check("r38_port", bus.req_data_out[32*k +: 32], 32'hA000_0000 + 32'(k));
            tick();
            tick();
        end
        check("r38_full", {bus.busy, bus.in_ready}, {4'hF, 1'b0});
        repeat (8) tick();
        bus.rsp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            check("r38_pop", {bus.rsp_port, bus.rsp_resp}, {2'(k), 2'd3});
            tick();
        end
        bus.rsp_ready = 0;
        tick();

        // single add through port 1
        bus.in_valid = 1; bus.in_cmd = 4'd1; bus.in_op1 = 32'hFFFF_0000;
        bus.in_op2 = 32'h0000_FFFF; bus.in_tag = 4'd3;
        tick();
        bus.in_valid = 0;
        check("r37_s1", {bus.req_cmd_out[3:0], bus.req_data_out[31:0]},
              {4'd1, 32'hFFFF_0000});
        tick();
        check("r37_s2", {bus.req_cmd_out[3:0], bus.req_data_out[31:0]},
              {4'd0, 32'h0000_FFFF});
        tick();
        bus.out_resp = 8'h01;
        bus.out_data = {96'd0, 32'hFFFF_FFFF};
        tick();
        bus.out_resp = '0;
        check("r37_rsp", {bus.rsp_valid, bus.rsp_resp, bus.rsp_data,
                          bus.rsp_tag, bus.rsp_port},
              {1'b1, 2'd1, 32'hFFFF_FFFF, 4'd3, 2'd0});
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;

        // simultaneous responses on ports 2 and 4 under back-pressure
        send(4'd2, 32'h10, 32'h11, 4'hB);
        send(4'd5, 32'h20, 32'h21, 4'hC);
        bus.in_valid = 1; bus.in_cmd = 4'd6; bus.in_op1 = 32'h30;
        bus.in_op2 = 32'h31; bus.in_tag = 4'hD;
        tick();
        bus.in_valid = 0;
        bus.out_resp = 8'h84;
        bus.out_data = {32'h3333_4444, 32'h0, 32'h1111_2222, 32'h0};
        tick();
        bus.out_resp = '0;
        repeat (3) begin
            check("r39_hold", {bus.rsp_port, bus.rsp_resp, bus.rsp_data, bus.rsp_tag},
                  {2'd1, 2'd1, 32'h1111_2222, 4'hB});
            tick();
        end
        bus.rsp_ready = 1;
        tick();
        check("r39_next", {bus.rsp_port, bus.rsp_resp, bus.rsp_data, bus.rsp_tag},
              {2'd3, 2'd2, 32'h3333_4444, 4'hD});
        tick();
        bus.rsp_ready = 0;
        drain();

        // timeout exactly TO cycles after the op2 cycle, then a late reply
        send(4'd1, 32'h55, 32'h66, 4'h7);
        repeat (6) tick();
        check("r40_early", bus.rsp_valid, 1'b0);
        tick();
        check("r40_tmo", {bus.rsp_valid, bus.rsp_resp, bus.rsp_data, bus.rsp_port},
              {1'b1, 2'd3, 32'd0, 2'd0});
        bus.out_resp = 8'h01;
        tick();
        bus.out_resp = '0;
        check("r40_perr", bus.proto_err, 1'b1);
        tick();
        check("r40_perr_end", bus.proto_err, 1'b0);
        drain();

        // stray response on idle port 3
        bus.out_resp = 8'h10;
        tick();
        bus.out_resp = '0;
        check("r41_perr", {bus.proto_err, bus.rsp_valid}, {1'b1, 1'b0});
        tick();
        check("r41_perr_end", bus.proto_err, 1'b0);

        // reset during SEND1, then dispatch restarts at port 1
        bus.in_valid = 1; bus.in_cmd = 4'd5; bus.in_op1 = 32'h77;
        bus.in_op2 = 32'h88; bus.in_tag = 4'h1;
        tick();
        bus.in_valid = 0;
        check("r42_send1", bus.req_cmd_out, 16'h0050);
        #2;
        reset = 1'b0;
        #1;
        check("r42_rst", {bus.req_cmd_out, bus.req_data_out, bus.busy,
                          bus.in_ready, bus.rsp_valid}, '0);
        m_reset();
        @(posedge c_clk);
        #1;
        reset = 1'b1;
        bus.in_valid = 1; bus.in_cmd = 4'd6; bus.in_op1 = 32'h99;
        bus.in_op2 = 32'hAA; bus.in_tag = 4'h2;
        tick();
        bus.in_valid = 0;
        check("r42_port1", bus.req_cmd_out, 16'h0006);
        tick();
        tick();
        drain();

        // random traffic, including one mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                reset = 1'b0;
                idle_in();
                tick();
                tick();
                reset = 1'b1;
            end
            bus.in_valid  = ($urandom % 2) == 1;
            bus.in_cmd    = cmds[$urandom % 4];
            bus.in_op1    = $urandom;
            bus.in_op2    = $urandom;
            bus.in_tag    = 4'($urandom);
            bus.out_resp  = '0;
            for (int p = 0; p < 4; p++)
                if ($urandom % 6 == 0)
                    bus.out_resp[2*p +: 2] = 2'($urandom_range(1, 2));
            bus.out_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.rsp_ready = ($urandom % 3) != 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/calc1_port_sched.md
CALC1_PORT_SCHED -- requirements
Module: calc1_port_sched

Interface
REQ-001 Parameter TIMEOUT, default 64: cycles to wait for a calc1 response, counted from the op2 cycle, before declaring a timeout (legal 2..255).
REQ-002 c_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting low clears all state immediately.
REQ-004 in_valid  input  1  client command valid.
REQ-005 in_ready  output  1  block can accept a command this cycle.
REQ-006 in_cmd  input  4  calc1 command: 1 add, 2 sub, 5 lsh, 6 rsh; forwarded unchanged.
REQ-007 in_op1, in_op2  input  32 each  operands 1 and 2.
REQ-008 in_tag  input  4  client tag, returned with the result.
REQ-009 req_cmd_out  output  16  calc1 command per port; port p (1..4) occupies bits 4(p-1)+:4.
REQ-010 req_data_out  output  128  calc1 data per port; port p occupies bits 32(p-1)+:32.
REQ-011 out_resp  input  8  calc1 response per port, 2 bits each: 0 none, 1 ok, 2 overflow/invalid.
REQ-012 out_data  input  128  calc1 result data per port, 32 bits each.
REQ-013 rsp_valid / rsp_ready  output / input  1 each  result handshake.
REQ-014 rsp_resp  output  2  result code: 1 ok, 2 error, 3 timeout.
REQ-015 rsp_data, rsp_tag, rsp_port  output  32, 4, 2  result data, original tag, and serving port (0..3 = ports 1..4).
REQ-016 busy  output  4  per-port occupied flag (bit p-1 = port p).
REQ-017 proto_err  output  1  one-cycle pulse on an unexpected calc1 response.

Function
REQ-018 The dispatch FSM SHALL have states IDLE, SEND1 and SEND2; in_ready SHALL equal (state==IDLE) and (at least one port not busy).
REQ-019 On an accept edge (in_valid&in_ready) the FSM SHALL select the first non-busy port at or after the dispatch round-robin pointer, set its busy bit, latch cmd/op1/op2/tag, and go to SEND1.
REQ-020 In SEND1 the FSM SHALL drive req_cmd_out[p]=cmd and req_data_out[p]=op1, then go to SEND2.
REQ-021 In SEND2 the FSM SHALL drive req_cmd_out[p]=0 and req_data_out[p]=op2, clear that port's timer, then return to IDLE; maximum throughput is one command per 3 cycles.
REQ-022 Any port not being driven in SEND1/SEND2 SHALL see cmd 0 and data 0; all req outputs SHALL be registered.
REQ-023 After each accept, the dispatch pointer SHALL become (p mod 4)+1.
REQ-024 Per-port timer (8 bits) SHALL increment each cycle while the port is busy, past SEND2, with no result pending.
REQ-025 When out_resp[p]!=0 on a busy, not-pending port, the block SHALL capture the code and data into port p's result slot and set pending[p].
REQ-026 When the timer reaches TIMEOUT with no response, the block SHALL set pending[p] with resp 3 and data 0.
REQ-027 A nonzero out_resp on a port that is not busy, or that is already pending, SHALL be ignored and SHALL pulse proto_err for one cycle.
REQ-028 rsp_valid SHALL equal OR(pending); the result slot SHALL be selected round-robin from the pop pointer.
REQ-029 The selection SHALL be locked while rsp_valid&!rsp_ready, keeping all rsp_* outputs stable.
REQ-030 On a pop edge (rsp_valid&rsp_ready) the block SHALL clear pending[p] and busy[p] and set the pop pointer to the next port.
REQ-031 A port freed by a pop SHALL be selectable for dispatch from the following cycle, not the same edge.
REQ-032 Responses on several ports in the same cycle SHALL all be captured, with none lost.

Reset
REQ-033 While reset is low, outputs SHALL be: in_ready=0, rsp_valid=0, busy=0, proto_err=0, req_cmd_out=0, req_data_out=0, and all rsp_* fields 0.
REQ-034 While reset is low, the FSM SHALL be in IDLE, both pointers SHALL select port 1, and timers and pending flags SHALL be 0.
REQ-035 Reset mid-operation SHALL discard all in-flight commands and results; the block does not reset calc1.
REQ-036 in_ready SHALL rise in the first cycle after reset deasserts.

Verification
REQ-037 Accept cmd 1, op1 0xFFFF0000, op2 0x0000FFFF, tag 3 -> port 1 sees 1/0xFFFF0000 then 0/0x0000FFFF; out_resp=1, out_data=0xFFFFFFFF -> rsp 1/0xFFFFFFFF/tag 3/port 0.
REQ-038 Four back-to-back commands with no responses -> dispatched to ports 1,2,3,4 in order; busy=0xF and in_ready=0 until the first pop.
REQ-039 Responses on ports 2 and 4 in the same cycle with rsp_ready low for 3 cycles -> rsp_* stable on port 2, then port 4 delivered, with both data values intact.
REQ-040 TIMEOUT=8 with no response -> rsp_resp=3 and rsp_data=0 exactly 8 cycles after the SEND2 cycle; a later response on that port pulses proto_err.
REQ-041 out_resp=1 on idle port 3 -> proto_err pulses and rsp_valid stays 0.
REQ-042 Reset asserted during SEND1 -> req outputs 0 and busy 0 immediately; after release, a new command dispatches to port 1.
